frame_write_arbiter: RTL and testbench

- Owns the single write port of the 640x480, 8-bit frame buffer (19-bit address).
- At each frame start it can optionally clear the buffer to a background colour.
- Outside the clear, it shares the write port round-robin between two pixel-writing requesters (e.g. sprite blitter, HUD/text writer).
- Sits between the requesters and the frame buffer's wraddress/data/wren inputs, timed off the VGA controller's vertical sync.

---
 rtl/frame_write_arbiter.sv | 139 +++++++++++++
 tb/tb_frame_write_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/frame_write_arbiter.sv
// Single write port of the frame buffer: an optional per-frame clear to a background
// colour, then round-robin sharing between two pixel-writing requesters.
module frame_write_arbiter #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vs,
  input  logic              clear_en,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] frame_wrAddress,
  output logic [DATA_W-1:0] frame_input,
  output logic              frame_we,
  output logic              clearing,
  output logic              frame_start,
  output logic              overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_ARB} state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_d;
  logic                frame_start_q, frame_start_d;
  logic                overrun_q, overrun_d;
  logic                rr_last_q, rr_last_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                we_q, we_d;
  logic                fs;
  logic                clear_last;

  assign fs            = vs_q & ~vs;
  assign vs_d          = vs;
  assign frame_start_d = fs;
  assign clear_last    = (clear_addr_q == ADDR_W'(FRAME_PIXELS - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      rr_last_q     <= 1'b1;
      clear_addr_q  <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      we_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      rr_last_q     <= rr_last_d;
      clear_addr_q  <= clear_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      we_q          <= we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (fs) begin
          state_d      = clear_en ? ST_CLEAR : ST_ARB;
          clear_addr_d = '0;
        end
      end
      ST_CLEAR: begin
        // A frame start during the clear is ignored here; it only flags overrun.
        clear_addr_d = clear_addr_q + ADDR_W'(1);
        if (clear_last) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (fs && clear_en) begin
          state_d      = ST_CLEAR;
          clear_addr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rr_last_d = rr_last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      ST_CLEAR: begin
        wr_addr_d = clear_addr_q;
        wr_data_d = clear_color;
        we_d      = 1'b1;
        if (fs) overrun_d = 1'b1;
      end
      ST_ARB: begin
        // On a tie the requester that did not win last time gets the port.
        if (req0 && (!req1 || rr_last_q)) begin
          gnt0      = 1'b1;
          rr_last_d = 1'b0;
          wr_addr_d = addr0;
          wr_data_d = data0;
          we_d      = 1'b1;
        end else if (req1) begin
          gnt1      = 1'b1;
          rr_last_d = 1'b1;
          wr_addr_d = addr1;
          wr_data_d = data1;
          we_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign frame_wrAddress = wr_addr_q;
  assign frame_input     = wr_data_q;
  assign frame_we        = we_q;
  assign clearing        = (state_q == ST_CLEAR);
  assign frame_start     = frame_start_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed bench for frame_write_arbiter with a 16-pixel frame: clear, round-robin
// arbitration, requests held off by a clear, overrun on a mid-clear frame start, reset.
module tb_frame_write_arbiter;

  localparam int FP     = 16;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vs = 1'b1;
  logic              clear_en = 1'b0;
  logic [DATA_W-1:0] clear_color = '0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] data0 = '0, data1 = '0;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] frame_wraddress;
  logic [DATA_W-1:0] frame_input;
  logic              frame_we, clearing, frame_start, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  frame_write_arbiter #(.FRAME_PIXELS(FP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk(clk), .Reset(rst), .vs(vs), .clear_en(clear_en), .clear_color(clear_color),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .frame_wrAddress(frame_wraddress), .frame_input(frame_input),
    .frame_we(frame_we), .clearing(clearing), .frame_start(frame_start), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input int a, input int d);
    chk({tag, "_we"}, 32'(frame_we), 32'd1);
    chk({tag, "_addr"}, 32'(frame_wraddress), 32'(a));
    chk({tag, "_data"}, 32'(frame_input), 32'(d));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(frame_we), 32'd0);
    chk("rst_clearing", 32'(clearing), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_addr", 32'(frame_wraddress), 32'd0);

    // Test 1: clear of 16 pixels to 8'h2A
    tick();
    clear_en = 1'b1; clear_color = 8'h2A; vs = 1'b0;
    tick();
    chk("t1_frame_start", 32'(frame_start), 32'd1);
    chk("t1_clearing", 32'(clearing), 32'd1);
    chk("t1_we_pre", 32'(frame_we), 32'd0);
    for (int i = 0; i < FP; i++) begin
      tick();
      chk_write($sformatf("t1_clr%0d", i), i, 8'h2A);
      chk($sformatf("t1_clearing%0d", i), 32'(clearing), 32'(i < FP - 1));
      chk($sformatf("t1_gnt%0d", i), 32'({gnt1, gnt0}), 32'd0);
      if (i == 0) chk("t1_fs_pulse_end", 32'(frame_start), 32'd0);
      if (i == 2) vs = 1'b1;
    end
    tick();
    chk("t1_we_after", 32'(frame_we), 32'd0);

    // Test 3: both requesters held for 4 grants, alternating 0,1,0,1
    req0 = 1'b1; addr0 = 19'd5; data0 = 8'hA0;
    req1 = 1'b1; addr1 = 19'd9; data1 = 8'hB0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_gnt0_%0d", k), 32'(gnt0), 32'(k % 2 == 0));
      chk($sformatf("t3_gnt1_%0d", k), 32'(gnt1), 32'(k % 2 == 1));
      tick();
      if (k % 2 == 0) chk_write($sformatf("t3_w%0d", k), 5, 8'hA0);
      else            chk_write($sformatf("t3_w%0d", k), 9, 8'hB0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("t3_we_idle", 32'(frame_we), 32'd0);
    chk("t3_addr_hold", 32'(frame_wraddress), 32'd9);

    // Test 2: single request on port 0
    req0 = 1'b1; addr0 = 19'h00100; data0 = 8'h11;
    #1;
    chk("t2_gnt0", 32'(gnt0), 32'd1);
    chk("t2_gnt1", 32'(gnt1), 32'd0);
    tick();
    req0 = 1'b0;
    chk_write("t2_w", 19'h00100, 8'h11);
    // Lone request on port 1 leaves requester 0 favoured for the next tie
    req1 = 1'b1; addr1 = 19'd7; data1 = 8'h77;
    #1;
    chk("t2b_gnt1", 32'(gnt1), 32'd1);
    chk("t2b_gnt0", 32'(gnt0), 32'd0);
    tick();
    req1 = 1'b0;
    chk_write("t2b_w", 7, 8'h77);

    // Tests 4 and 5: requests pending across a clear, second frame start mid-clear
    clear_color = 8'h55; vs = 1'b0;
    tick();
    chk("t4_clearing", 32'(clearing), 32'd1);
    req0 = 1'b1; addr0 = 19'd3; data0 = 8'hC3;
    req1 = 1'b1; addr1 = 19'd4; data1 = 8'hC4;
    for (int i = 0; i < FP; i++) begin
      #1;
      chk($sformatf("t4_gnt%0d", i), 32'({gnt1, gnt0}), 32'd0);
      tick();
      chk_write($sformatf("t4_clr%0d", i), i, 8'h55);
      chk($sformatf("t5_ovr%0d", i), 32'(overrun), 32'(i >= 8));
      if (i == 6) vs = 1'b1;
      if (i == 7) vs = 1'b0;
    end
    #1;
    chk("t4_first_gnt0", 32'(gnt0), 32'd1);
    chk("t4_first_gnt1", 32'(gnt1), 32'd0);
    tick();
    req0 = 1'b0;
    chk_write("t4_w0", 3, 8'hC3);
    #1;
    chk("t4_then_gnt1", 32'(gnt1), 32'd1);
    tick();
    req1 = 1'b0;
    chk_write("t4_w1", 4, 8'hC4);
    tick();
    chk("t5_ovr_sticky", 32'(overrun), 32'd1);

    // Test 6: reset in the middle of a clear
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    chk("t6_clearing", 32'(clearing), 32'd1);
    for (int i = 0; i <= 5; i++) tick();
    chk_write("t6_pre", 5, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_we", 32'(frame_we), 32'd0);
    chk("t6_async_clearing", 32'(clearing), 32'd0);
    chk("t6_async_ovr", 32'(overrun), 32'd0);
    vs = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; addr0 = 19'd12; data0 = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t6_idle_gnt%0d", i), 32'({gnt1, gnt0}), 32'd0);
      tick();
      chk($sformatf("t6_idle_we%0d", i), 32'(frame_we), 32'd0);
    end
    clear_en = 1'b0; vs = 1'b0;
    tick();
    #1;
    chk("t6_arb_gnt0", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0;
    chk_write("t6_w", 12, 8'hEE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
